pll_acq_ctrl: RTL and testbench
===============================

Name: pll_acq_ctrl

Overview:
- Acquisition and lock sequencer for the software NCO PLL (10-bit frequency word, 50 MHz system clock).
- Sweeps the NCO frequency word to find the feedback input, then enables the phase-detector slew loop and qualifies lock.
- Drops into holdover when the feedback signal disappears.
- Drives the NCO frequency-load path, the loop-enable gate and the lock LED/status.

Parameters:
- FREQ_MIN_RAW, 10'd65: sweep start and lower bound (≈50 kHz).
- FREQ_MAX_RAW, 10'd524: sweep upper bound (≈400 kHz).
- FREQ_STEP, 10'd4: sweep increment per dwell.
- DWELL_CYC, 16'd20000: clk_50 cycles per sweep step.
- LOCK_WIN, 8'd3: max fb/vco edge separation in cycles for a "good" comparison.
- LOCK_COUNT, 8'd32: consecutive good comparisons required to declare lock.
- UNLOCK_COUNT, 8'd4: consecutive bad comparisons in LOCKED that force a return to TRACK.
- NOSIG_CYC, 16'd2000: cycles without fb_edge before HOLDOVER.

Ports:
- clk_50 in 1: system clock, 50 MHz.
- rst_n in 1: asynchronous active-low reset.
- fb_edge in 1: one-cycle pulse on a synchronized feedback rising edge.
- vco_edge in 1: one-cycle pulse on a (delay-matched) NCO rising edge.
- restart in 1: synchronous request to return to IDLE.
- freq_set out 10: frequency word presented to the NCO.
- freq_load out 1: one-cycle strobe; the NCO loads freq_set on it.
- loop_en out 1: gates the slew_fast/slew_slow path into the NCO.
- locked out 1: lock qualified.
- state out 3: IDLE=0, SWEEP=1, TRACK=2, LOCKED=3, HOLDOVER=4.

Behaviour:
Reset values:
- state=IDLE, freq_set=FREQ_MIN_RAW, freq_load=0, loop_en=0, locked=0.
- All counters are 0.

Signal-loss timer:
- nosig counts cycles since the last fb_edge and saturates at NOSIG_CYC.
- fb_edge clears it to 0.

IDLE:
- First fb_edge sets freq_set=FREQ_MIN_RAW, pulses freq_load next cycle, and goes to SWEEP.

SWEEP (loop_en=0):
- dwell counts 0..DWELL_CYC-1.
- fcnt and vcnt (8-bit, saturating) count fb_edge and vco_edge within the dwell.
- At dwell end:
  - If |fcnt-vcnt|<=1 and fcnt>=2: go to TRACK and assert loop_en from the following cycle.
  - Otherwise: freq_set += FREQ_STEP, with one freq_load pulse. If the sum exceeds FREQ_MAX_RAW, freq_set wraps to FREQ_MIN_RAW. Counters clear.
- freq_load is exactly one cycle per update. It is never asserted in TRACK or LOCKED.

Phase comparison (TRACK and LOCKED):
- The first of fb_edge/vco_edge opens a window, and win counts cycles.
- The other edge arriving with win<=LOCK_WIN is a good comparison.
- win exceeding LOCK_WIN is a bad comparison; the window closes.
- fb_edge and vco_edge in the same cycle is good, with separation 0.
- A second edge of the same kind while the window is open is bad; a new window opens on that edge.

TRACK (loop_en=1):
- good increments gcnt (saturating); bad clears gcnt.
- gcnt==LOCK_COUNT: go to LOCKED with locked=1 on the same edge.

LOCKED:
- bad increments bcnt; good clears bcnt.
- bcnt==UNLOCK_COUNT: go to TRACK with locked=0 and gcnt=0.

HOLDOVER:
- Entered from TRACK or LOCKED when nosig reaches NOSIG_CYC.
- Sets loop_en=0 and locked=0; freq_set is held.
- Next fb_edge goes to TRACK with gcnt=0.
- From SWEEP, nosig==NOSIG_CYC goes to IDLE instead.

restart:
- Goes to IDLE next cycle from any state and clears all counters.
- restart has priority over every other transition.
- Reset asserted mid-sweep or mid-lock returns all outputs to reset values immediately (asynchronous).

Arithmetic:
- The freq_set step is computed in 11 bits before the bound compare, so there is no silent 10-bit wrap.

Optional Feature:
- Macro: PLL_ACQ_LOSS_STATS_EN.
- When defined:
  - Adds output loss_cnt (16 bits, saturating at 16'hFFFF).
  - loss_cnt increments on every LOCKED→TRACK or LOCKED→HOLDOVER transition.
  - It clears on rst_n only, not on restart.
- When undefined: no port and no logic; all other behaviour is identical.

Test Plan:
1. Reset, then drive fb_edge every 400 cycles (125 kHz) with vco_edge absent → state SWEEP; freq_set = 65, 69, 73, … stepping every 20000 cycles; one freq_load pulse per step.
2. In SWEEP with freq_set at 524 and no match → next dwell end gives freq_set=65 with one freq_load.
3. vco_edge tracking fb_edge at a 400-cycle period with 2-cycle offset → TRACK after the matching dwell; locked=1 exactly on the 32nd consecutive good comparison.
4. From LOCKED, shift vco_edge to a 10-cycle offset → locked drops after the 4th bad comparison; state=2.
5. From LOCKED, stop fb_edge → state=4 and loop_en=0 exactly 2000 cycles after the last fb_edge; freq_set unchanged. Resume fb_edge → state=2.
6. Assert restart during TRACK in the same cycle a good comparison completes → state=0 and gcnt=0. With PLL_ACQ_LOSS_STATS_EN defined, loss_cnt counts the scenario 4 and 5 losses (=2).

Source files
------------

// File: rtl/pll_acq_ctrl.sv
// pll_acq_ctrl: NCO PLL sweep/track/lock sequencer with holdover on feedback loss.
// Define PLL_ACQ_LOSS_STATS_EN to add the saturating loss_cnt lock-loss counter.
module pll_acq_ctrl #(
    parameter logic [9:0]  FREQ_MIN_RAW = 10'd65,
    parameter logic [9:0]  FREQ_MAX_RAW = 10'd524,
    parameter logic [9:0]  FREQ_STEP    = 10'd4,
    parameter logic [15:0] DWELL_CYC    = 16'd20000,
    parameter logic [7:0]  LOCK_WIN     = 8'd3,
    parameter logic [7:0]  LOCK_COUNT   = 8'd32,
    parameter logic [7:0]  UNLOCK_COUNT = 8'd4,
    parameter logic [15:0] NOSIG_CYC    = 16'd2000
) (
    input  logic       clk_50,
    input  logic       rst_n,
    input  logic       fb_edge,
    input  logic       vco_edge,
    input  logic       restart,
    output logic [9:0] freq_set,
    output logic       freq_load,
    output logic       loop_en,
    output logic       locked,
`ifdef PLL_ACQ_LOSS_STATS_EN
    output logic [15:0] loss_cnt,
`endif
    output logic [2:0] state
);
    localparam logic [2:0] IDLE = 3'd0, SWEEP = 3'd1, TRACK = 3'd2, LOCKED = 3'd3, HOLD = 3'd4;

    logic [15:0] nosig, dwell, nosig_n;
    logic [7:0]  fcnt, vcnt, fcnt_n, vcnt_n, diff, win, gcnt, bcnt, gcnt_n, bcnt_n;
    logic [10:0] step_sum;
    logic [9:0]  freq_next;
    logic        sig_lost, match, win_open, win_fb, other, same, good, bad;

    always_comb begin
        nosig_n   = fb_edge ? 16'd0 : (nosig == NOSIG_CYC ? nosig : nosig + 16'd1);
        sig_lost  = nosig_n == NOSIG_CYC;
        fcnt_n    = fcnt + 8'(fb_edge && fcnt != 8'hFF);
        vcnt_n    = vcnt + 8'(vco_edge && vcnt != 8'hFF);
        diff      = fcnt_n >= vcnt_n ? fcnt_n - vcnt_n : vcnt_n - fcnt_n;
        match     = diff <= 8'd1 && fcnt_n >= 8'd2;
        // 11-bit sum so a step past the 10-bit range still wraps to the sweep start
        step_sum  = {1'b0, freq_set} + {1'b0, FREQ_STEP};
        freq_next = step_sum > {1'b0, FREQ_MAX_RAW} ? FREQ_MIN_RAW : step_sum[9:0];
        other     = win_fb ? vco_edge : fb_edge;
        same      = win_fb ? fb_edge : vco_edge;
        good      = win_open ? other && win <= LOCK_WIN : fb_edge && vco_edge;
        bad       = win_open && (other ? win > LOCK_WIN : same || win > LOCK_WIN);
        gcnt_n    = good ? gcnt + 8'(gcnt != 8'hFF) : (bad ? 8'd0 : gcnt);
        bcnt_n    = bad ? bcnt + 8'(bcnt != 8'hFF) : (good ? 8'd0 : bcnt);
    end

    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            freq_set  <= FREQ_MIN_RAW;
            freq_load <= 1'b0;
            loop_en   <= 1'b0;
            locked    <= 1'b0;
            nosig     <= '0;
            dwell     <= '0;
            fcnt      <= '0;
            vcnt      <= '0;
            win       <= '0;
            win_open  <= 1'b0;
            win_fb    <= 1'b0;
            gcnt      <= '0;
            bcnt      <= '0;
        end else begin
            freq_load <= 1'b0;
            nosig     <= nosig_n;
            if (restart) begin
                state    <= IDLE;
                loop_en  <= 1'b0;
                locked   <= 1'b0;
                nosig    <= '0;
                dwell    <= '0;
                fcnt     <= '0;
                vcnt     <= '0;
                win      <= '0;
                win_open <= 1'b0;
                gcnt     <= '0;
                bcnt     <= '0;
            end else begin
                case (state)
                    IDLE: if (fb_edge) begin
                        state     <= SWEEP;
                        freq_set  <= FREQ_MIN_RAW;
                        freq_load <= 1'b1;
                        dwell     <= '0;
                        fcnt      <= '0;
                        vcnt      <= '0;
                    end
                    SWEEP: begin
                        dwell <= dwell + 16'd1;
                        fcnt  <= fcnt_n;
                        vcnt  <= vcnt_n;
                        if (sig_lost || dwell == DWELL_CYC - 16'd1) begin
                            dwell <= '0;
                            fcnt  <= '0;
                            vcnt  <= '0;
                        end
                        if (sig_lost)
                            state <= IDLE;
                        else if (dwell == DWELL_CYC - 16'd1 && match) begin
                            state    <= TRACK;
                            loop_en  <= 1'b1;
                            win_open <= 1'b0;
                            gcnt     <= '0;
                            bcnt     <= '0;
                        end else if (dwell == DWELL_CYC - 16'd1) begin
                            freq_set  <= freq_next;
                            freq_load <= 1'b1;
                        end
                    end
                    TRACK, LOCKED: if (sig_lost) begin
                        state    <= HOLD;
                        loop_en  <= 1'b0;
                        locked   <= 1'b0;
                        win_open <= 1'b0;
                        gcnt     <= '0;
                        bcnt     <= '0;
                    end else begin
                        if (win_open) begin
                            if (other || (!same && win > LOCK_WIN))
                                win_open <= 1'b0;
                            else
                                win <= same ? 8'd1 : win + 8'd1;
                        end else if (fb_edge ^ vco_edge) begin
                            win_open <= 1'b1;
                            win_fb   <= fb_edge;
                            win      <= 8'd1;
                        end
                        if (state == TRACK) begin
                            gcnt <= gcnt_n;
                            bcnt <= '0;
                            if (gcnt_n == LOCK_COUNT) begin
                                state  <= LOCKED;
                                locked <= 1'b1;
                            end
                        end else begin
                            bcnt <= bcnt_n;
                            if (bcnt_n == UNLOCK_COUNT) begin
                                state  <= TRACK;
                                locked <= 1'b0;
                                gcnt   <= '0;
                                bcnt   <= '0;
                            end
                        end
                    end
                    HOLD: if (fb_edge) begin
                        state    <= TRACK;
                        loop_en  <= 1'b1;
                        win_open <= 1'b0;
                        gcnt     <= '0;
                        bcnt     <= '0;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef PLL_ACQ_LOSS_STATS_EN
    logic loss;
    assign loss = !restart && state == LOCKED && (sig_lost || bcnt_n == UNLOCK_COUNT);

    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n)
            loss_cnt <= '0;
        else if (loss && loss_cnt != 16'hFFFF)
            loss_cnt <= loss_cnt + 16'd1;
    end
`endif
endmodule

// File: tb/tb_pll_acq_ctrl.sv
// tb_pll_acq_ctrl: directed acquisition/lock/holdover sequence with a freq_load scoreboard.
module tb_pll_acq_ctrl;
    logic       clk_50 = 1'b0, rst_n = 1'b0, fb_edge = 1'b0, vco_edge = 1'b0, restart = 1'b0;
    logic [9:0] freq_set;
    logic       freq_load, loop_en, locked;
    logic [2:0] state;
`ifdef PLL_ACQ_LOSS_STATS_EN
    logic [15:0] loss_cnt;
`endif

    typedef struct {
        int         c;
        logic [9:0] f;
    } ld_t;
    ld_t q[$];
    int  n = 0, err = 0, cyc = 0;

    pll_acq_ctrl #(.FREQ_MAX_RAW(10'd77), .DWELL_CYC(16'd2000)) dut (
        .clk_50(clk_50), .rst_n(rst_n), .fb_edge(fb_edge), .vco_edge(vco_edge),
        .restart(restart), .freq_set(freq_set), .freq_load(freq_load),
        .loop_en(loop_en), .locked(locked),
`ifdef PLL_ACQ_LOSS_STATS_EN
        .loss_cnt(loss_cnt),
`endif
        .state(state)
    );

    always #10 clk_50 = ~clk_50;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n++;
        assert (obs === exp) else begin
            err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input logic f, input logic v);
        ld_t e;
        fb_edge  = f;
        vco_edge = v;
        @(negedge clk_50);
        fb_edge  = 1'b0;
        vco_edge = 1'b0;
        cyc++;
        if (freq_load === 1'b1) begin
            if (q.size() == 0)
                chk("unexpected_load", freq_load, 0);
            else begin
                e = q.pop_front();
                chk("load_cycle", cyc, e.c);
                chk("load_freq", freq_set, e.f);
            end
        end
    endtask

    task automatic span(input int from, input int to, input int off);
        for (int i = from; i < to; i++) step(i == 0, i == off);
    endtask

    initial begin
        @(negedge clk_50);
        @(negedge clk_50);
        chk("rst_state", state, 0);
        chk("rst_freq", freq_set, 65);
        chk("rst_load", freq_load, 0);
        chk("rst_loop_en", loop_en, 0);
        chk("rst_locked", locked, 0);
        rst_n = 1'b1;
        step(1'b0, 1'b1);
        chk("idle_ignores_vco", state, 0);
        cyc = 0;
        q.push_back('{1, 10'd65});
        q.push_back('{2001, 10'd69});
        q.push_back('{4001, 10'd73});
        q.push_back('{6001, 10'd77});
        q.push_back('{8001, 10'd65});
        step(1'b1, 1'b0);
        chk("sweep_entry", state, 1);
        chk("sweep_loop_en", loop_en, 0);
        span(1, 400, -1);
        for (int p = 1; p < 20; p++) span(0, 400, -1);
        for (int p = 20; p < 25; p++) span(0, 400, 2);
        chk("sweep_before_match", state, 1);
        chk("sweep_loads_done", q.size(), 0);
        span(0, 1, 2);
        chk("track_entry", state, 2);
        chk("track_loop_en", loop_en, 1);
        chk("track_freq", freq_set, 65);
        span(1, 400, 2);
        for (int p = 26; p < 57; p++) span(0, 400, 2);
        span(0, 2, 2);
        chk("pre_lock_state", state, 2);
        chk("pre_lock_locked", locked, 0);
        span(2, 3, 2);
        chk("lock_state", state, 3);
        chk("lock_locked", locked, 1);
        span(3, 400, 2);
        span(0, 400, 10);
        chk("two_bad_locked", locked, 1);
        span(0, 14, 10);
        chk("three_bad_locked", locked, 1);
        span(14, 15, 10);
        chk("unlock_state", state, 2);
        chk("unlock_locked", locked, 0);
        chk("unlock_loop_en", loop_en, 1);
        span(15, 400, 10);
        for (int p = 0; p < 32; p++) span(0, 400, 2);
        chk("relock_state", state, 3);
        span(1, 1601, -1);
        chk("pre_hold_state", state, 3);
        span(1, 2, -1);
        chk("hold_state", state, 4);
        chk("hold_loop_en", loop_en, 0);
        chk("hold_locked", locked, 0);
        chk("hold_freq", freq_set, 65);
        span(0, 1, -1);
        chk("resume_state", state, 2);
        chk("resume_loop_en", loop_en, 1);
        span(1, 400, -1);
        span(0, 2, -1);
        restart = 1'b1;
        step(1'b0, 1'b1);
        restart = 1'b0;
        chk("restart_state", state, 0);
        chk("restart_loop_en", loop_en, 0);
        chk("restart_locked", locked, 0);
`ifdef PLL_ACQ_LOSS_STATS_EN
        chk("loss_cnt", loss_cnt, 2);
`endif
        q.push_back('{cyc + 1, 10'd65});
        q.push_back('{cyc + 2001, 10'd69});
        for (int p = 0; p < 5; p++) span(0, 400, -1);
        span(0, 1, -1);
        chk("resweep_state", state, 1);
        chk("resweep_loads_done", q.size(), 0);
        #5 rst_n = 1'b0;
        #1;
        chk("async_rst_state", state, 0);
        chk("async_rst_freq", freq_set, 65);
        chk("async_rst_load", freq_load, 0);
        chk("async_rst_loop_en", loop_en, 0);
`ifdef PLL_ACQ_LOSS_STATS_EN
        chk("async_rst_loss_cnt", loss_cnt, 0);
`endif
        $display("Result: errors=%0d of %0d checks", err, n);
        $finish;
    end
endmodule
